// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package ex_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_signed_a(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // MULHSU treats rs2 as unsigned, so only three ops have a signed b.
    function automatic logic op_signed_b(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // MULH, MULHSU and MULHU return the upper half of the product.
    function automatic logic op_sel_high(input muldiv_op_t op);
        return !op[2] && (op[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_md_sign_fix.sv
// Conditional two's-complement negate; gives |x| on operands and applies the result sign.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide execute unit: one bit per cycle, shift-add multiply and
// restoring divide on operand magnitudes, with the sign applied when the result is registered.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [TAG_W-1:0] resp_tag
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t        state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             neg_res_q, neg_res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

    muldiv_op_t       req_op_e;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             accept;
    logic             div_by_zero, div_ovf;
    logic [WIDTH-1:0] special_data;

    assign req_op_e  = muldiv_op_t'(req_op);
    assign req_ready = (state_q == MD_IDLE) && !rst;
    assign accept    = req_valid && req_ready && !flush;

    assign neg_a = op_signed_a(req_op_e) && req_a[WIDTH-1];
    assign neg_b = op_signed_b(req_op_e) && req_b[WIDTH-1];

    md_sign_fix #(.W(WIDTH)) u_abs_a (
        .val_i (req_a),
        .neg_i (neg_a),
        .val_o (mag_a)
    );

    md_sign_fix #(.W(WIDTH)) u_abs_b (
        .val_i (req_b),
        .neg_i (neg_b),
        .val_o (mag_b)
    );

    assign div_by_zero = op_is_div(req_op_e) && (req_b == '0);
    assign div_ovf     = ((req_op_e == OP_DIV) || (req_op_e == OP_REM)) &&
                         (req_a == MIN_VAL) && (req_b == '1);

    always_comb begin
        special_data = '0;
        if (div_by_zero) begin
            special_data = op_is_rem(req_op_e) ? req_a : '1;
        end else if (div_ovf) begin
            special_data = op_is_rem(req_op_e) ? '0 : MIN_VAL;
        end
    end

    // Multiply keeps {hi, lo} as the 2*WIDTH product with the multiplier shifting out of lo;
    // divide shifts the dividend out of lo into hi and the quotient bits into lo.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rs;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   iter_hi, iter_lo;
    logic [2*WIDTH-1:0] raw_res, fixed_res;
    logic [WIDTH-1:0]   final_res;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
    assign div_rs   = {hi_q, lo_q[WIDTH-1]};
    assign div_ge   = (div_rs >= {1'b0, opd_q});
    assign div_diff = div_rs[WIDTH-1:0] - opd_q;

    always_comb begin
        if (op_is_div(op_q)) begin
            iter_hi = div_ge ? div_diff : div_rs[WIDTH-1:0];
            iter_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        if (!op_is_div(op_q)) begin
            raw_res = {iter_hi, iter_lo};
        end else if (op_is_rem(op_q)) begin
            raw_res = {{WIDTH{1'b0}}, iter_hi};
        end else begin
            raw_res = {{WIDTH{1'b0}}, iter_lo};
        end
    end

    md_sign_fix #(.W(2*WIDTH)) u_fix_res (
        .val_i (raw_res),
        .neg_i (neg_res_q),
        .val_o (fixed_res)
    );

    assign final_res = op_sel_high(op_q) ? fixed_res[2*WIDTH-1:WIDTH] : fixed_res[WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        tag_d        = tag_q;
        neg_res_d    = neg_res_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        opd_d        = opd_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;

        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    op_d      = req_op_e;
                    tag_d     = req_tag;
                    neg_res_d = op_is_rem(req_op_e) ? neg_a : (neg_a ^ neg_b);
                    cnt_d     = CNT_W'(WIDTH);
                    if (div_by_zero || div_ovf) begin
                        state_d      = MD_DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = special_data;
                        resp_tag_d   = req_tag;
                    end else begin
                        state_d = MD_CALC;
                        hi_d    = '0;
                        lo_d    = op_is_div(req_op_e) ? mag_a : mag_b;
                        opd_d   = op_is_div(req_op_e) ? mag_b : mag_a;
                    end
                end
            end
            MD_CALC: begin
                hi_d  = iter_hi;
                lo_d  = iter_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = MD_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = final_res;
                    resp_tag_d   = tag_q;
                end
            end
            MD_DONE: begin
                if (resp_ready) begin
                    state_d      = MD_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = MD_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase

        if (flush) begin
            state_d      = MD_IDLE;
            resp_valid_d = 1'b0;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MD_IDLE;
            op_q         <= OP_MUL;
            tag_q        <= '0;
            neg_res_q    <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            opd_q        <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            neg_res_q    <= neg_res_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            opd_q        <= opd_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: fixed vectors, random ops against a 64-bit model,
// back-pressure, flush and mid-op reset.
module tb_ex_muldiv_unit;

    localparam int W = 32;
    localparam int T = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [T-1:0] req_tag;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic [T-1:0] resp_tag;

    int vectors = 0;
    int miscompares = 0;
    int resp_count = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [T-1:0] tag;
        int           lat;
    } exp_t;

    exp_t scb[$];

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WIDTH(W), .TAG_W(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag)
    );

    always @(posedge clk) if (resp_valid && resp_ready) resp_count++;

    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sbv, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        p   = '0;
        case (op)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sbv; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sbv; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [T-1:0] tag, input logic [W-1:0] exp_data);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        e.data    = exp_data;
        e.tag     = tag;
        e.lat     = exp_lat(op, a, b);
        scb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        exp_t e;
        int   lat = 0;
        if (scb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty: queue size 0 required >0");
            return;
        end
        e = scb.pop_front();
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 100);
        vectors++;
        if (resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
            return;
        end
        vectors++;
        if (lat !== e.lat) begin
            miscompares++;
            $display("FAIL latency: got %0d required %0d", lat, e.lat);
        end
        vectors++;
        if (resp_data !== e.data) begin
            miscompares++;
            $display("FAIL resp_data: got %h required %h", resp_data, e.data);
        end
        vectors++;
        if (resp_tag !== e.tag) begin
            miscompares++;
            $display("FAIL resp_tag: got %h required %h", resp_tag, e.tag);
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL after_consume: resp_valid=%b req_ready=%b required 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== '0 || resp_tag !== '0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h tag=%h required 0/0/0/0",
                     req_ready, resp_valid, resp_data, resp_tag);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_fixed();
        logic [2:0]   ops [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [W-1:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                  32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] xs  [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                  32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], as[i], bs[i], T'(i + 1), xs[i]);
            wait_resp();
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            issue(op, a, b, T'($urandom_range(0, 31)), ref_model(op, a, b));
            wait_resp();
            consume();
        end
    endtask

    task automatic test_backpressure();
        issue(3'd5, 32'd1000, 32'd33, 5'd21, 32'd30);
        wait_resp();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== 1'b1 || resp_data !== 32'd30 || resp_tag !== 5'd21 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold: vld=%b data=%h tag=%h rdy=%b required 1/1e/15/0",
                         resp_valid, resp_data, resp_tag, req_ready);
            end
        end
        consume();
    endtask

    task automatic test_flush();
        int base;
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_a     = 32'd5;
        req_b     = 32'd0;
        req_tag   = 5'd7;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_blocks_accept: vld=%b rdy=%b required 0/1", resp_valid, req_ready);
        end
        base = resp_count;
        issue(3'd0, 32'd123, 32'd456, 5'd3, 32'd56088);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(scb.pop_back());
        @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_idle: vld=%b rdy=%b required 0/1", resp_valid, req_ready);
        end
        issue(3'd5, 32'd9, 32'd3, 5'd12, 32'd3);
        wait_resp();
        consume();
        repeat (40) @(negedge clk);
        vectors++;
        if (resp_count - base !== 1) begin
            miscompares++;
            $display("FAIL flush_resp_count: got %0d required 1", resp_count - base);
        end
    endtask

    task automatic test_rst_mid();
        issue(3'd7, 32'd1000, 32'd7, 5'd9, 32'd6);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ready: req_ready=%b required 0", req_ready);
        end
        @(negedge clk);
        void'(scb.pop_back());
        vectors++;
        if (resp_valid !== 1'b0 || resp_data !== '0 || resp_tag !== '0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: vld=%b data=%h tag=%h rdy=%b required all 0",
                     resp_valid, resp_data, resp_tag, req_ready);
        end
        rst = 1'b0;
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd30, 32'hFFFF_FFFF);
        wait_resp();
        consume();
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        resp_ready = 1'b0;
        test_reset();
        test_fixed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
